// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Pipelined immediate generator between decode and execute. An entry of
//   {instruction, immediate format, tag} is accepted on a valid/ready
//   handshake. Its immediate is extended to XLEN bits at the input and stored
//   in a 2-entry FIFO. The FIFO is a head (output) register plus a skid
//   register, so the stage keeps full throughput under backpressure.
//
// Parameters
//   XLEN   width of out_imm (32 or 64)
//   TAG_W  width of the sideband tag carried alongside each entry
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous; discards every buffered entry
//   in_valid / in_ready   input handshake (in_ready depends on occupancy only)
//   in_instr              raw 32-bit instruction word
//   in_imm_src            immediate format select
//   in_tag                sideband tag
//   out_valid / out_ready output handshake
//   out_imm               extended immediate of the head entry
//   out_tag               tag of the head entry
//   out_illegal           head entry used the reserved format 3'b111
//   illegal_cnt           saturating count of accepted illegal entries
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [15:0]      illegal_cnt
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_U   = 3'b010,
    FMT_Z   = 3'b011,
    FMT_SH  = 3'b100,
    FMT_B   = 3'b101,
    FMT_J   = 3'b110,
    FMT_ILL = 3'b111
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Immediate extension (combinational, at the input)
  // ---------------------------------------------------------------------------
  logic        w_sign;
  logic [31:0] w_raw;       // 32-bit immediate, sign-extended unless w_zext
  logic        w_zext;
  logic        w_illegal;
  logic [XLEN-1:0] w_imm;
  entry_t      w_new;
  logic        w_unused_opcode;

  assign w_sign          = in_instr[31];
  assign w_unused_opcode = ^in_instr[6:0];

  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_raw     = '0;
    w_zext    = 1'b0;
    w_illegal = 1'b0;
    case (fmt_e'(in_imm_src))
      FMT_I:   w_raw = {{20{w_sign}}, in_instr[31:20]};
      FMT_S:   w_raw = {{20{w_sign}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   w_raw = {{20{w_sign}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U:   w_raw = {in_instr[31:12], 12'b0};
      FMT_J:   w_raw = {{12{w_sign}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      FMT_Z: begin
        w_raw  = {27'b0, in_instr[19:15]};
        w_zext = 1'b1;
      end
      FMT_SH: begin
        // RV64 shift amounts are 6 bits, RV32 only 5.
        w_raw  = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        w_zext = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // The size cast of a signed operand replicates bit 31 into the upper half
  // when XLEN=64 (U format included) and is an identity when XLEN=32.
  assign w_imm = w_zext ? XLEN'(w_raw) : XLEN'($signed(w_raw));
  assign w_new = '{imm: w_imm, tag: in_tag, illegal: w_illegal};

  // ---------------------------------------------------------------------------
  // 2-entry FIFO: head register drives out_*, skid register catches the entry
  // that arrives while the head is stalled.
  // ---------------------------------------------------------------------------
  occ_e   r_occ;
  entry_t r_head;
  entry_t r_skid;
  logic [15:0] r_illegal_cnt;
  logic   w_accept;
  logic   w_pop;

  assign in_ready  = (r_occ != OCC_FULL);
  assign out_valid = (r_occ != OCC_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the entry registers are reset as well because out_imm/out_tag must
  // read zero after reset, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ         <= OCC_EMPTY;
      r_head        <= '0;
      r_skid        <= '0;
      r_illegal_cnt <= '0;
    end else if (flush) begin
      // Handshakes in the flush cycle are void; contents become don't-care.
      r_occ <= OCC_EMPTY;
    end else begin
      if (w_accept && w_illegal && (r_illegal_cnt != 16'hFFFF))
        r_illegal_cnt <= r_illegal_cnt + 16'd1;

      case (r_occ)
        OCC_EMPTY: begin
          if (w_accept) begin
            r_head <= w_new;
            r_occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_accept && w_pop) begin
            r_head <= w_new;
          end else if (w_accept) begin
            r_skid <= w_new;
            r_occ  <= OCC_FULL;
          end else if (w_pop) begin
            r_occ  <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            r_head <= r_skid;
            r_occ  <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

  assign out_imm     = r_head.imm;
  assign out_tag     = r_head.tag;
  assign out_illegal = r_head.illegal;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag32, tag64;
  logic [15:0]      cnt32, cnt64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a queue of expected entries plus an illegal counter.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0]      imm32;   // value expected from the XLEN=32 instance (low half)
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag;
    bit               ill;
  } exp_t;

  exp_t q[$];
  int   m_cnt = 0;

  // Immediate value as a 64-bit integer, from the format field layouts.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input bit is64);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    longint v;
    v = 0;
    case (src)
      3'd0: begin i12 = ins[31:20]; v = i12; end
      3'd1: begin i12 = {ins[31:25], ins[11:7]}; v = i12; end
      3'd5: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = b13; end
      3'd2: begin u32 = {ins[31:12], 12'h000}; v = u32; end
      3'd6: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = j21; end
      3'd3: v = longint'(ins[19:15]);
      3'd4: v = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    return v;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    exp_t e;
    bit   acc, pop;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() != 2);
      pop = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.imm32 = ref_imm(in_instr, in_imm_src, 1'b0);
        e.imm64 = ref_imm(in_instr, in_imm_src, 1'b1);
        e.tag   = in_tag;
        e.ill   = (in_imm_src == 3'b111);
        q.push_back(e);
        if (e.ill && m_cnt != 16'hFFFF) m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_checks++;
    if ({ov32, ov64, rdy32, rdy64, ill32, ill64} !== 6'b001100) begin
      n_errors++;
      $display("FAIL reset_flags: got ov=%b/%b rdy=%b/%b ill=%b/%b, want ov=0 rdy=1 ill=0",
               ov32, ov64, rdy32, rdy64, ill32, ill64);
    end
    n_checks++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== '0 || tag64 !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got imm=%h/%h tag=%h/%h, want zeros", imm32, imm64, tag32, tag64);
    end
    n_checks++;
    if (cnt32 !== 16'h0 || cnt64 !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %h/%h, want 0000", cnt32, cnt64);
    end
  endtask

  task automatic test_formats();
    logic [31:0] v_instr [8] = '{32'hFFF00093, 32'hFE000FA3, 32'hFE000EE3, 32'h800000B7,
                                 32'h8000006F, 32'h000F8000, 32'h03F00000, 32'h00000013};
    logic [2:0]  v_src   [8] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd4, 3'd0};
    logic [31:0] v_e32   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h80000000,
                                 32'hFFF00000, 32'h0000001F, 32'h0000001F, 32'h00000000};
    logic [63:0] v_e64   [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                                 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                                 64'hFFFFFFFFFFF00000, 64'h000000000000001F,
                                 64'h000000000000003F, 64'h0000000000000000};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_instr   = v_instr[i];
      in_imm_src = v_src[i];
      in_tag     = TAG_W'(i);
      step();
      n_checks++;
      if (ov32 !== 1'b1 || imm32 !== v_e32[i] || ill32 !== 1'b0 || tag32 !== TAG_W'(i)) begin
        n_errors++;
        $display("FAIL fmt32[%0d]: got v=%b imm=%h ill=%b tag=%0d, want v=1 imm=%h ill=0 tag=%0d",
                 i, ov32, imm32, ill32, tag32, v_e32[i], i);
      end
      n_checks++;
      if (ov64 !== 1'b1 || imm64 !== v_e64[i] || ill64 !== 1'b0) begin
        n_errors++;
        $display("FAIL fmt64[%0d]: got v=%b imm=%h ill=%b, want v=1 imm=%h ill=0",
                 i, ov64, imm64, ill64, v_e64[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      n_errors++;
      $display("FAIL fmt_drain: got out_valid=%b/%b, want 0", ov32, ov64);
    end
  endtask

  task automatic test_illegal();
    out_ready  = 1'b1;
    in_imm_src = 3'b111;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = $urandom();
      in_tag   = TAG_W'(20 + i);
      step();
      n_checks++;
      if (ov32 !== 1'b1 || ill32 !== 1'b1 || imm32 !== 32'h0 || ill64 !== 1'b1 || imm64 !== 64'h0) begin
        n_errors++;
        $display("FAIL illegal[%0d]: got v=%b ill=%b/%b imm=%h/%h, want v=1 ill=1 imm=0",
                 i, ov32, ill32, ill64, imm32, imm64);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (cnt32 !== 16'd3 || cnt64 !== 16'd3) begin
      n_errors++;
      $display("FAIL illegal_cnt: got %0d/%0d, want 3", cnt32, cnt64);
    end
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] seen[$];
    logic [TAG_W-1:0] want[3] = '{5'd1, 5'd2, 5'd3};
    logic [2:0]       want_rdy = 3'b110;
    out_ready  = 1'b0;
    in_imm_src = 3'd0;
    in_instr   = 32'h00100093;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(i + 1);
      n_checks++;
      if (rdy32 !== want_rdy[2-i] || rdy64 !== want_rdy[2-i]) begin
        n_errors++;
        $display("FAIL bp_ready[%0d]: got %b/%b, want %b", i, rdy32, rdy64, want_rdy[2-i]);
      end
      step();
    end
    n_checks++;
    if (ov32 !== 1'b1 || tag32 !== 5'd1 || rdy32 !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_hold: got v=%b tag=%0d rdy=%b, want v=1 tag=1 rdy=0", ov32, tag32, rdy32);
    end
    // Tag 3 stays offered until it is taken.
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (ov32 === 1'b1) seen.push_back(tag32);
      if (in_valid && rdy32 === 1'b1 && c > 0) begin
        step();
        in_valid = 1'b0;
      end else begin
        step();
      end
    end
    n_checks++;
    if (seen.size() != 3) begin
      n_errors++;
      $display("FAIL bp_count: got %0d entries out, want 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seen[i] !== want[i]) begin
          n_errors++;
          $display("FAIL bp_order[%0d]: got tag %0d, want %0d", i, seen[i], want[i]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int cnt_before;
    out_ready  = 1'b0;
    in_imm_src = 3'd2;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instr = $urandom();
      in_tag   = TAG_W'(i + 4);
      step();
    end
    n_checks++;
    if (rdy32 !== 1'b0 || ov32 !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_setup: got rdy=%b v=%b, want rdy=0 v=1", rdy32, ov32);
    end
    cnt_before = m_cnt;
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_imm_src = 3'b111;
    in_tag     = 5'd9;
    out_ready  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_state: got v=%b/%b rdy=%b/%b, want v=0 rdy=1", ov32, ov64, rdy32, rdy64);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_leak[%0d]: got v=%b/%b tag=%0d, want v=0", c, ov32, ov64, tag32);
      end
    end
    n_checks++;
    if (cnt32 !== 16'(cnt_before) || cnt64 !== 16'(cnt_before)) begin
      n_errors++;
      $display("FAIL flush_cnt: got %0d/%0d, want %0d", cnt32, cnt64, cnt_before);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      in_instr   = $urandom();
      in_imm_src = 3'($urandom_range(0, 7));
      in_tag     = TAG_W'($urandom());
      step();
      n_checks++;
      if (ov32 !== (q.size() != 0) || ov64 !== (q.size() != 0) ||
          rdy32 !== (q.size() != 2) || rdy64 !== (q.size() != 2)) begin
        n_errors++;
        $display("FAIL rnd_hs[%0d]: got v=%b/%b rdy=%b/%b, want occ=%0d", c, ov32, ov64, rdy32,
                 rdy64, q.size());
      end
      n_checks++;
      if (cnt32 !== 16'(m_cnt) || cnt64 !== 16'(m_cnt)) begin
        n_errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d, want %0d", c, cnt32, cnt64, m_cnt);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (imm32 !== q[0].imm32[31:0] || imm64 !== q[0].imm64 || tag32 !== q[0].tag ||
            tag64 !== q[0].tag || ill32 !== q[0].ill || ill64 !== q[0].ill) begin
          n_errors++;
          $display("FAIL rnd_data[%0d]: got imm=%h/%h tag=%0d/%0d ill=%b/%b, want imm=%h/%h tag=%0d ill=%b",
                   c, imm32, imm64, tag32, tag64, ill32, ill64, q[0].imm32[31:0], q[0].imm64,
                   q[0].tag, q[0].ill);
        end
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_imm_src = 3'b111;
    for (int c = 0; c < 65540; c++) step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (cnt32 !== 16'hFFFF || cnt64 !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL saturate: got %h/%h, want FFFF", cnt32, cnt64);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready  = 1'b0;
    in_imm_src = 3'd0;
    in_instr   = 32'hFFF00093;
    in_valid   = 1'b1;
    in_tag     = 5'd7;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || imm32 !== 32'h0 || imm64 !== 64'h0 ||
        tag32 !== '0 || ill32 !== 1'b0 || cnt32 !== 16'h0 || cnt64 !== 16'h0 || rdy32 !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_async: got v=%b/%b imm=%h/%h tag=%0d ill=%b cnt=%h/%h rdy=%b, want zeros rdy=1",
               ov32, ov64, imm32, imm64, tag32, ill32, cnt32, cnt64, rdy32);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_cnt = 0;
    step();
    n_checks++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || cnt32 !== 16'h0) begin
      n_errors++;
      $display("FAIL rst_release: got v=%b rdy=%b cnt=%h, want v=0 rdy=1 cnt=0", ov32, rdy32, cnt32);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_formats();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturation();
    test_reset_midstream();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
